// File: rtl/report_collector.sv
// report_collector: samples an automaton's report vector on each symbol step.
// Every non-zero vector is tagged with its symbol index and queued in a small
// FIFO that drains over a valid/ready handshake. Sticky summary state is kept
// alongside the FIFO.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   clear         synchronous clear of all state; wins over everything else
//   rpt_en        report vector valid; one pulse per consumed symbol
//   rpt_vec       automaton report outputs
//   out_valid     FIFO head valid (occupancy != 0)
//   out_ready     consumer accepts the head
//   out_rpt       head entry report vector (qualified by out_valid)
//   out_idx       head entry symbol index (qualified by out_valid)
//   sticky_rpt    OR of all sampled reports since clear
//   first_valid   at least one report seen since clear
//   first_idx     symbol index of the first report since clear
//   overflow      sticky; an entry was dropped on a full FIFO
//   drop_cnt      saturating count of dropped entries
//   irq           out_valid OR overflow
module report_collector #(
    parameter int unsigned NUM_REPORTS = 4,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned DROP_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   rpt_en,
    input  logic [NUM_REPORTS-1:0] rpt_vec,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_REPORTS-1:0] out_rpt,
    output logic [CNT_W-1:0]       out_idx,
    output logic [NUM_REPORTS-1:0] sticky_rpt,
    output logic                   first_valid,
    output logic [CNT_W-1:0]       first_idx,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_cnt,
    output logic                   irq
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    logic [CNT_W-1:0]       sym_cnt;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [OCC_W-1:0]       occ;
    logic [NUM_REPORTS-1:0] mem_rpt [DEPTH];
    logic [CNT_W-1:0]       mem_idx [DEPTH];

    logic hit;
    logic pop;
    logic full;
    logic accept;
    logic drop;

    // Handshake and push/drop decisions; a pop frees the slot a full push needs.
    always_comb begin
        hit    = rpt_en && (rpt_vec != '0);
        full   = (occ == OCC_FULL);
        pop    = out_valid && out_ready;
        accept = hit && (!full || pop);
        drop   = hit && full && !pop;
    end

    assign out_valid = (occ != '0);
    assign out_rpt   = mem_rpt[rd_ptr];
    assign out_idx   = mem_idx[rd_ptr];
    assign irq       = out_valid | overflow;

    // FIFO storage is not reset; the head is only meaningful with out_valid.
    always_ff @(posedge clk) begin
        if (accept && !clear) begin
            mem_rpt[wr_ptr] <= rpt_vec;
            mem_idx[wr_ptr] <= sym_cnt;
        end
    end

    // Counter, pointers, occupancy and sticky summary state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_cnt     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            sticky_rpt  <= '0;
            first_valid <= 1'b0;
            first_idx   <= '0;
            overflow    <= 1'b0;
            drop_cnt    <= '0;
        end else if (clear) begin
            sym_cnt     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            sticky_rpt  <= '0;
            first_valid <= 1'b0;
            first_idx   <= '0;
            overflow    <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            if (rpt_en) begin
                sym_cnt <= sym_cnt + CNT_W'(1);
            end
            // DEPTH is a power of two, so pointers wrap naturally.
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
            if (hit) begin
                sticky_rpt <= sticky_rpt | rpt_vec;
                if (!first_valid) begin
                    first_valid <= 1'b1;
                    first_idx   <= sym_cnt;
                end
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + DROP_W'(1);
                end
            end
        end
    end

endmodule
